ser_byte_framer: RTL
====================

// Module: ser_byte_framer
// PURPOSE
// - Consumes the serial bit stream (bit_in/bit_wr, MSB-first) produced by the post-unscramble serializer.
// - Hunts for a SYNC_LEN-bit sync word, then packs the following FRAME_BYTES*8 bits into bytes.
// - Writes the bytes to a downstream byte FIFO, with SOF/EOF markers, and returns to hunting after each frame.
// - The bit stream has no back-pressure. FIFO overflow drops the frame and sets a sticky flag.
// PARAMETERS
// SYNC_LEN     16        sync word width in bits, 2..32
// SYNC_WORD    16'hF628  sync pattern; the first bit received is the MSB
// FRAME_BYTES  188       payload bytes per frame, >=2; BCW = $clog2(FRAME_BYTES)
// PORTS
// clk          in   1    clock
// rst          in   1    reset, synchronous, active-low
// clk_en       in   1    global clock enable; all state holds while low
// bit_in       in   1    serial data bit
// bit_wr       in   1    bit_in valid; a bit is accepted when clk_en && bit_wr
// fifo_full    in   1    downstream byte FIFO full
// ovf_clr      in   1    clears the sticky overflow flag
// byte_out     out  8    packed byte, MSB = first bit received
// byte_wr      out  1    1-cycle write strobe to the byte FIFO
// byte_sof     out  1    qualifies byte_wr: first byte of the frame
// byte_eof     out  1    qualifies byte_wr: last byte of the frame
// locked       out  1    1 while in LOCKED
// overflow     out  1    sticky: a byte was dropped because the FIFO was full
// frame_cnt    out  16   count of completed frames; wraps at 16'hFFFF -> 0
// BEHAVIOUR
// - Reset (rst==0 at posedge clk) applies regardless of clk_en.
//   - All outputs are 0 after reset, and the state is HUNT.
//   - sync_sr, byte_sr, bit_cnt and byte_cnt are all 0.
// - "acc" means clk_en && bit_wr in the current cycle. Every action below happens only on an acc cycle.
// - HUNT:
//   - sync_sr <= {sync_sr[SYNC_LEN-2:0], bit_in} on every acc.
//   - If {sync_sr[SYNC_LEN-2:0], bit_in} == SYNC_WORD:
//     - go to LOCKED; bit_cnt <= 0; byte_cnt <= 0.
//   - The sync bit itself is not a payload bit; payload starts with the next accepted bit.
// - LOCKED:
//   - byte_sr <= {byte_sr[6:0], bit_in}; bit_cnt <= bit_cnt+1 (3-bit, wraps).
//   - When bit_cnt==7, the byte is complete: B = {byte_sr[6:0], bit_in}.
//     - If fifo_full==0 (next cycle):
//       - byte_wr=1 and byte_out=B.
//       - byte_sof = (byte_cnt==0).
//       - byte_eof = (byte_cnt==FRAME_BYTES-1).
//     - If fifo_full==1:
//       - no write; overflow <= 1.
//       - go to HUNT; sync_sr <= 0; the frame is abandoned.
//     - If byte_cnt==FRAME_BYTES-1 and the write succeeds:
//       - byte_cnt <= 0; frame_cnt <= frame_cnt+1.
//       - go to HUNT; sync_sr <= 0, so a full new sync word is required.
//     - Otherwise byte_cnt <= byte_cnt+1.
// - Output timing:
//   - byte_wr/byte_sof/byte_eof are registered and asserted only in the cycle after the completing bit.
//   - They are 0 in every other cycle, including cycles with clk_en low.
//   - byte_out holds its last value.
//   - locked is registered and mirrors the state (1 from the cycle after sync match).
// - Latency: last bit of a byte accepted at edge N -> byte_wr high during cycle N+1.
// - fifo_full is sampled in the same cycle as the completing bit.
// - overflow:
//   - set by a drop; cleared by ovf_clr when clk_en is high.
//   - If a drop and ovf_clr occur in the same cycle, set wins.
// - The sync pattern appearing inside a payload is ignored: no re-sync while LOCKED.
// - Reset mid-frame discards partial bytes with no write and no EOF.
// - clk_en low with bit_wr high: the bit is ignored and no state changes.
// TESTING
// 1. Params SYNC=16'hF628, FRAME_BYTES=4. Send F628 then 32'hDEADBEEF -> bytes DE(sof),AD,BE,EF(eof); frame_cnt=1; locked 1->0.
// 2. Send 3'b101 noise, then F628, then payload 11223344 -> same framing; the noise produces no writes.
// 3. Payload contains F628 mid-frame (F6 28 00 01) -> 4 bytes written unchanged; no re-sync.
// 4. fifo_full=1 when the 2nd byte completes -> only byte 1 is written; overflow=1; HUNT. Next F628+frame -> 4 writes; overflow stays 1 until ovf_clr.
// 5. Toggle clk_en low with bit_wr high between bits -> ignored bits; output identical to test 1; byte_wr never high while clk_en=0.
// 6. rst=0 after 12 payload bits -> all outputs 0 and HUNT; the following F628+frame decodes cleanly with sof on the first byte.

Source files
------------

// File: rtl/ser_byte_framer.sv
// Serial-to-byte framer: hunts a sync word, then packs FRAME_BYTES payload bytes MSB-first.
// byte_wr is registered, one cycle after the completing bit; a full FIFO drops the frame and sets a sticky flag.
module ser_byte_framer #(
    parameter int                  SYNC_LEN    = 16,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD   = 16'hF628,
    parameter int                  FRAME_BYTES = 188
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        bit_in,
    input  logic        bit_wr,
    input  logic        fifo_full,
    input  logic        ovf_clr,
    output logic [7:0]  byte_out,
    output logic        byte_wr,
    output logic        byte_sof,
    output logic        byte_eof,
    output logic        locked,
    output logic        overflow,
    output logic [15:0] frame_cnt
);
    localparam int BCW = $clog2(FRAME_BYTES);

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [SYNC_LEN-1:0] sync_sr, sync_d, sync_next;
    logic [7:0]          byte_sr, byte_sr_d, byte_next;
    logic [2:0]          bit_cnt, bit_cnt_d;
    logic [BCW-1:0]      byte_cnt, byte_cnt_d;
    logic [7:0]          byte_out_d;
    logic                byte_wr_d, byte_sof_d, byte_eof_d;
    logic                overflow_d;
    logic [15:0]         frame_cnt_d;
    logic                acc, last_byte;

    assign acc       = clk_en && bit_wr;
    assign sync_next = {sync_sr[SYNC_LEN-2:0], bit_in};
    assign byte_next = {byte_sr[6:0], bit_in};
    assign last_byte = (byte_cnt == BCW'(FRAME_BYTES - 1));
    assign locked    = (state_q == LOCKED);

    always_comb begin
        state_d     = state_q;
        sync_d      = sync_sr;
        byte_sr_d   = byte_sr;
        bit_cnt_d   = bit_cnt;
        byte_cnt_d  = byte_cnt;
        byte_out_d  = byte_out;
        byte_wr_d   = 1'b0;
        byte_sof_d  = 1'b0;
        byte_eof_d  = 1'b0;
        overflow_d  = overflow;
        frame_cnt_d = frame_cnt;

        if (clk_en && ovf_clr)
            overflow_d = 1'b0;

        if (acc) begin
            case (state_q)
                HUNT: begin
                    sync_d = sync_next;
                    if (sync_next == SYNC_WORD) begin
                        state_d    = LOCKED;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    byte_sr_d = byte_next;
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (fifo_full) begin
                            // drop has priority over a same-cycle clear
                            overflow_d = 1'b1;
                            state_d    = HUNT;
                            sync_d     = '0;
                        end else begin
                            byte_wr_d  = 1'b1;
                            byte_out_d = byte_next;
                            byte_sof_d = (byte_cnt == '0);
                            byte_eof_d = last_byte;
                            if (last_byte) begin
                                byte_cnt_d  = '0;
                                frame_cnt_d = frame_cnt + 16'd1;
                                state_d     = HUNT;
                                sync_d      = '0;
                            end else begin
                                byte_cnt_d = byte_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= HUNT;
            sync_sr   <= '0;
            byte_sr   <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            byte_out  <= '0;
            byte_wr   <= 1'b0;
            byte_sof  <= 1'b0;
            byte_eof  <= 1'b0;
            overflow  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state_q   <= state_d;
            sync_sr   <= sync_d;
            byte_sr   <= byte_sr_d;
            bit_cnt   <= bit_cnt_d;
            byte_cnt  <= byte_cnt_d;
            byte_out  <= byte_out_d;
            byte_wr   <= byte_wr_d;
            byte_sof  <= byte_sof_d;
            byte_eof  <= byte_eof_d;
            overflow  <= overflow_d;
            frame_cnt <= frame_cnt_d;
        end
    end
endmodule
